sim_run_controller: RTL and testbench

Run controller that sequences the simulator's cycle loop under host command. It accepts RUN / PAUSE / STEP / CLEAR commands over a valid/ready port and drives a per-cycle advance enable (`sim_en`) to the simulated network. It also owns the authoritative simulated-cycle count and reports run state and completion. It sits between the host/testbench command source and the network's cycle-advance logic.

---
 rtl/sim_ctrl_pkg.sv | 21 ++
 rtl/sim_cycle_counter.sv | 40 ++++
 rtl/sim_run_controller.sv | 142 ++++++++++++++
 tb/tb_sim_run_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulator run controller: state and opcode encodings.
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUNNING  = 3'd1,
    ST_PAUSED   = 3'd2,
    ST_STEPPING = 3'd3,
    ST_DONE     = 3'd4
  } sim_state_e;

  typedef enum logic [1:0] {
    OP_RUN   = 2'b00,
    OP_PAUSE = 2'b01,
    OP_STEP  = 2'b10,
    OP_CLEAR = 2'b11
  } sim_op_e;

  localparam int unsigned STATE_W = 3;

endpackage

// File: rtl/sim_cycle_counter.sv
// Saturating counter with synchronous clear, load and enable; DOWN selects
// a down-counter that holds at zero instead of an up-counter holding at all-ones.
module sim_cycle_counter
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter bit          DOWN  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_limit;

  always_comb begin
    at_limit = DOWN ? (count_q == '0) : (count_q == '1);
    count_d  = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && !at_limit) begin
      count_d = DOWN ? (count_q - 1'b1) : (count_q + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/sim_run_controller.sv
// Run controller: sequences RUN/PAUSE/STEP/CLEAR host commands into a per-cycle
// advance enable and owns the authoritative simulated-cycle count.
module sim_run_controller
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CYCLE_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [MAX_CYCLE_WIDTH-1:0] cmd_arg,
  output logic                       sim_en,
  output logic [MAX_CYCLE_WIDTH-1:0] current_cycle,
  output logic [STATE_W-1:0]         state,
  output logic                       done_pulse,
  output logic                       cmd_err
);

  localparam int unsigned W = MAX_CYCLE_WIDTH;
  localparam logic [W-1:0] ALL_ONES = '1;

  sim_state_e     state_q, state_d;
  logic [W-1:0]   stop_q, stop_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [W-1:0]   cc, step_left, step_val;
  logic [W:0]     cc_next;
  logic           accept, limit_hit, sat_hit, cc_clr, step_load;
  sim_op_e        op;

  assign sim_en    = (state_q == ST_RUNNING) || (state_q == ST_STEPPING);
  assign cmd_ready = (state_q != ST_STEPPING);
  assign accept    = cmd_valid && cmd_ready;
  assign op        = sim_op_e'(cmd_op);

  // Limits compared one bit wider so cc+1 never wraps back below the stop cycle.
  assign cc_next   = {1'b0, cc} + 1'b1;
  assign limit_hit = cc_next >= {1'b0, stop_q};
  assign sat_hit   = cc_next >= {1'b0, ALL_ONES};
  assign step_val  = (cmd_arg == '0) ? W'(1) : cmd_arg;

  always_comb begin
    state_d   = state_q;
    stop_d    = stop_q;
    err_d     = 1'b0;
    cc_clr    = 1'b0;
    step_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_PAUSED: begin
        if (accept) begin
          case (op)
            OP_RUN: begin
              stop_d  = cmd_arg;
              state_d = (cmd_arg <= cc) ? ST_DONE : ST_RUNNING;
            end
            OP_STEP: begin
              step_load = 1'b1;
              state_d   = ST_STEPPING;
            end
            OP_CLEAR: begin
              state_d = ST_IDLE;
              stop_d  = '0;
              cc_clr  = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_RUNNING: begin
        if (accept && op == OP_CLEAR) begin
          state_d = ST_IDLE;
          stop_d  = '0;
          cc_clr  = 1'b1;
        end else begin
          // Hitting the limit outranks a concurrent PAUSE, which is then not an error.
          if (limit_hit || sat_hit)         state_d = ST_DONE;
          else if (accept && op == OP_PAUSE) state_d = ST_PAUSED;
          if (accept && (op == OP_RUN || op == OP_STEP)) err_d = 1'b1;
        end
      end
      ST_STEPPING: begin
        if (sat_hit)                  state_d = ST_DONE;
        else if (step_left == W'(1))  state_d = ST_PAUSED;
      end
      ST_DONE: begin
        if (accept) begin
          if (op == OP_CLEAR) begin
            state_d = ST_IDLE;
            stop_d  = '0;
            cc_clr  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      stop_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  sim_cycle_counter #(.WIDTH(W), .DOWN(1'b0)) u_cycle (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (cc_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (sim_en),
    .count_o    (cc)
  );

  sim_cycle_counter #(.WIDTH(W), .DOWN(1'b1)) u_step (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (cc_clr),
    .load_i     (step_load),
    .load_val_i (step_val),
    .en_i       (state_q == ST_STEPPING),
    .count_o    (step_left)
  );

  assign current_cycle = cc;
  assign state         = state_q;
  assign done_pulse    = done_q;
  assign cmd_err       = err_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Self-checking bench for sim_run_controller: directed scenarios plus a
// randomized command sequence checked against a transaction-level model.
module tb_sim_run_controller;

  localparam logic [2:0] IDLE = 3'd0, RUNNING = 3'd1, PAUSED = 3'd2, DONE = 3'd4;
  localparam logic [1:0] RUN = 2'b00, PAUSE = 2'b01, STEP = 2'b10, CLEAR = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        v32, rdy32, en32, dp32, er32;
  logic [1:0]  op32;
  logic [31:0] arg32, cc32;
  logic [2:0]  st32;
  logic        v4, rdy4, en4, dp4, er4;
  logic [1:0]  op4;
  logic [3:0]  arg4, cc4;
  logic [2:0]  st4;

  int n_chk = 0, n_fail = 0;
  int en_cnt32 = 0, en_cnt4 = 0, rlow32 = 0, dcnt32 = 0;

  sim_run_controller dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(v32), .cmd_ready(rdy32), .cmd_op(op32),
    .cmd_arg(arg32), .sim_en(en32), .current_cycle(cc32), .state(st32),
    .done_pulse(dp32), .cmd_err(er32)
  );

  sim_run_controller #(.MAX_CYCLE_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(v4), .cmd_ready(rdy4), .cmd_op(op4),
    .cmd_arg(arg4), .sim_en(en4), .current_cycle(cc4), .state(st4),
    .done_pulse(dp4), .cmd_err(er4)
  );

  always @(posedge clk) begin
    if (en32)   en_cnt32++;
    if (en4)    en_cnt4++;
    if (!rdy32) rlow32++;
    if (dp32)   dcnt32++;
  end

  task automatic issue(input bit nar, input logic [1:0] op, input logic [31:0] arg);
    if (nar) begin v4 = 1'b1; op4 = op; arg4 = arg[3:0]; end
    else     begin v32 = 1'b1; op32 = op; arg32 = arg; end
    @(posedge clk);
    #1 v32 = 1'b0; v4 = 1'b0;
  endtask

  task automatic send(input bit nar, input logic [1:0] op, input logic [31:0] arg);
    int t = 0;
    @(negedge clk);
    while (!(nar ? rdy4 : rdy32) && t < 100) begin @(negedge clk); t++; end
    n_chk++;
    if ((nar ? rdy4 : rdy32) !== 1'b1) begin
      n_fail++; $display("FAIL cmd_ready_timeout: cmd_ready=%0b required 1", nar ? rdy4 : rdy32);
    end
    issue(nar, op, arg);
  endtask

  task automatic wait_st(input bit nar, input logic [2:0] tgt, input int budget);
    int t = 0;
    @(negedge clk);
    while ((nar ? st4 : st32) !== tgt && t < budget) begin @(negedge clk); t++; end
    n_chk++;
    if ((nar ? st4 : st32) !== tgt) begin
      n_fail++; $display("FAIL wait_state: state=%0d required %0d", nar ? st4 : st32, tgt);
    end
  endtask

  task automatic wait_cc(input logic [31:0] tgt, input int budget);
    int t = 0;
    @(negedge clk);
    while (cc32 !== tgt && t < budget) begin @(negedge clk); t++; end
    n_chk++;
    if (cc32 !== tgt) begin
      n_fail++; $display("FAIL wait_cycle: current_cycle=%0d required %0d", cc32, tgt);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; v32 = 1'b0; op32 = '0; arg32 = '0; v4 = 1'b0; op4 = '0; arg4 = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    n_chk++; if (st32 !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", st32, IDLE); end
    n_chk++; if (cc32 !== 32'd0) begin n_fail++; $display("FAIL reset_cycle: got %0d expected 0", cc32); end
    n_chk++; if ({en32, rdy32, dp32, er32} !== 4'b0100) begin
      n_fail++; $display("FAIL reset_outputs: en/rdy/done/err=%b expected 0100", {en32, rdy32, dp32, er32});
    end
    n_chk++; if ({st4, cc4} !== 7'd0) begin n_fail++; $display("FAIL reset_narrow: state=%0d cycle=%0d expected 0/0", st4, cc4); end
  endtask

  task automatic test_run_to_done();
    en_cnt32 = 0; dcnt32 = 0;
    send(0, RUN, 32'd5);
    wait_st(0, DONE, 40);
    n_chk++; if (en_cnt32 !== 5) begin n_fail++; $display("FAIL run5_en_cycles: got %0d expected 5", en_cnt32); end
    n_chk++; if (cc32 !== 32'd5) begin n_fail++; $display("FAIL run5_cycle: got %0d expected 5", cc32); end
    n_chk++; if (dp32 !== 1'b1) begin n_fail++; $display("FAIL run5_done_pulse: got %0b expected 1", dp32); end
    @(negedge clk);
    n_chk++; if (dp32 !== 1'b0) begin n_fail++; $display("FAIL run5_done_one_cycle: got %0b expected 0", dp32); end
    send(0, RUN, 32'd9);
    @(negedge clk);
    n_chk++; if (er32 !== 1'b1) begin n_fail++; $display("FAIL run_in_done_err: got %0b expected 1", er32); end
    n_chk++; if (cc32 !== 32'd5 || st32 !== DONE) begin
      n_fail++; $display("FAIL run_in_done_hold: cycle=%0d state=%0d expected 5/%0d", cc32, st32, DONE);
    end
    @(negedge clk);
    n_chk++; if (er32 !== 1'b0 || dcnt32 !== 1) begin
      n_fail++; $display("FAIL run_in_done_pulses: err=%0b done_count=%0d expected 0/1", er32, dcnt32);
    end
  endtask

  task automatic test_pause_step();
    send(0, CLEAR, 32'd0);
    @(negedge clk);
    n_chk++; if (st32 !== IDLE || cc32 !== 32'd0) begin
      n_fail++; $display("FAIL clear: state=%0d cycle=%0d expected %0d/0", st32, cc32, IDLE);
    end
    send(0, RUN, 32'd100);
    wait_cc(32'd10, 50);
    issue(0, PAUSE, 32'd0);
    @(negedge clk);
    n_chk++; if (st32 !== PAUSED || cc32 !== 32'd11 || er32 !== 1'b0) begin
      n_fail++; $display("FAIL pause: state=%0d cycle=%0d err=%0b expected %0d/11/0", st32, cc32, er32, PAUSED);
    end
    en_cnt32 = 0; rlow32 = 0;
    send(0, STEP, 32'd3);
    wait_st(0, PAUSED, 20);
    n_chk++; if (rlow32 !== 3 || en_cnt32 !== 3) begin
      n_fail++; $display("FAIL step3_cycles: ready_low=%0d en=%0d expected 3/3", rlow32, en_cnt32);
    end
    n_chk++; if (cc32 !== 32'd14) begin n_fail++; $display("FAIL step3_cycle: got %0d expected 14", cc32); end
  endtask

  task automatic test_step_zero();
    send(0, CLEAR, 32'd0);
    en_cnt32 = 0;
    send(0, STEP, 32'd0);
    wait_st(0, PAUSED, 20);
    n_chk++; if (en_cnt32 !== 1 || cc32 !== 32'd1) begin
      n_fail++; $display("FAIL step0: en=%0d cycle=%0d expected 1/1", en_cnt32, cc32);
    end
  endtask

  task automatic test_run_zero();
    send(0, CLEAR, 32'd0);
    en_cnt32 = 0;
    send(0, RUN, 32'd0);
    @(negedge clk);
    n_chk++; if (st32 !== DONE || dp32 !== 1'b1 || en_cnt32 !== 0 || cc32 !== 32'd0) begin
      n_fail++; $display("FAIL run0: state=%0d done=%0b en=%0d cycle=%0d expected %0d/1/0/0", st32, dp32, en_cnt32, cc32, DONE);
    end
  endtask

  task automatic test_pause_at_limit();
    send(0, CLEAR, 32'd0);
    send(0, RUN, 32'd6);
    wait_cc(32'd5, 30);
    issue(0, PAUSE, 32'd0);
    @(negedge clk);
    n_chk++; if (st32 !== DONE || dp32 !== 1'b1 || er32 !== 1'b0 || cc32 !== 32'd6) begin
      n_fail++; $display("FAIL pause_at_limit: state=%0d done=%0b err=%0b cycle=%0d expected %0d/1/0/6", st32, dp32, er32, cc32, DONE);
    end
  endtask

  task automatic test_narrow();
    en_cnt4 = 0;
    send(1, RUN, 32'd15);
    wait_st(1, DONE, 40);
    n_chk++; if (cc4 !== 4'd15 || en_cnt4 !== 15 || dp4 !== 1'b1) begin
      n_fail++; $display("FAIL narrow_run15: cycle=%0d en=%0d done=%0b expected 15/15/1", cc4, en_cnt4, dp4);
    end
    repeat (3) @(negedge clk);
    n_chk++; if (cc4 !== 4'd15 || st4 !== DONE || en4 !== 1'b0) begin
      n_fail++; $display("FAIL narrow_no_wrap: cycle=%0d state=%0d en=%0b expected 15/%0d/0", cc4, st4, en4, DONE);
    end
    send(1, CLEAR, 32'd0);
    @(negedge clk);
    n_chk++; if (st4 !== IDLE || cc4 !== 4'd0) begin
      n_fail++; $display("FAIL narrow_clear: state=%0d cycle=%0d expected %0d/0", st4, cc4, IDLE);
    end
  endtask

  task automatic test_reset_mid_run();
    send(0, CLEAR, 32'd0);
    send(0, RUN, 32'd1000);
    wait_cc(32'd7, 30);
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (en32 !== 1'b0 || st32 !== IDLE || cc32 !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: en=%0b state=%0d cycle=%0d expected 0/%0d/0", en32, st32, cc32, IDLE);
    end
    n_chk++; if ({rdy32, dp32, er32} !== 3'b100) begin
      n_fail++; $display("FAIL async_reset_flags: rdy/done/err=%b expected 100", {rdy32, dp32, er32});
    end
    @(negedge clk);
    reset_n = 1'b1;
    send(0, PAUSE, 32'd0);
    @(negedge clk);
    n_chk++; if (er32 !== 1'b1 || st32 !== IDLE) begin
      n_fail++; $display("FAIL pause_in_idle: err=%0b state=%0d expected 1/%0d", er32, st32, IDLE);
    end
  endtask

  // Model tracks only the resting state and cycle count between commands.
  task automatic test_random();
    int unsigned m_cc, arg, span, d, k, r;
    logic [2:0] m_st;
    send(0, CLEAR, 32'd0);
    m_cc = 0; m_st = IDLE;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (m_st == DONE) begin
        if (r < 6) begin
          send(0, 2'($urandom_range(0, 2)), $urandom);
          @(negedge clk);
          n_chk++; if (er32 !== 1'b1 || st32 !== DONE || cc32 !== m_cc) begin
            n_fail++; $display("FAIL rnd_done_cmd[%0d]: err=%0b state=%0d cycle=%0d expected 1/%0d/%0d", i, er32, st32, cc32, DONE, m_cc);
          end
        end else begin
          send(0, CLEAR, $urandom);
          m_cc = 0; m_st = IDLE;
          @(negedge clk);
          n_chk++; if (st32 !== IDLE || cc32 !== 32'd0) begin
            n_fail++; $display("FAIL rnd_clear[%0d]: state=%0d cycle=%0d expected %0d/0", i, st32, cc32, IDLE);
          end
        end
      end else if (r < 4) begin
        arg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, m_cc) : m_cc + $urandom_range(1, 12);
        span = (arg > m_cc) ? arg - m_cc : 0;
        en_cnt32 = 0;
        send(0, RUN, arg);
        if (span == 0) begin
          @(negedge clk);
          m_st = DONE;
        end else if (span >= 2 && $urandom_range(0, 1) == 1) begin
          d = $urandom_range(0, span - 2);
          wait_cc(m_cc + d, 40);
          issue(0, PAUSE, 32'd0);
          @(negedge clk);
          m_cc = m_cc + d + 1; m_st = PAUSED;
        end else begin
          wait_st(0, DONE, 40);
          m_cc = arg; m_st = DONE;
        end
        n_chk++; if (st32 !== m_st || cc32 !== m_cc) begin
          n_fail++; $display("FAIL rnd_run[%0d]: state=%0d cycle=%0d expected %0d/%0d", i, st32, cc32, m_st, m_cc);
        end
      end else if (r < 7) begin
        k = $urandom_range(0, 5);
        en_cnt32 = 0;
        send(0, STEP, k);
        wait_st(0, PAUSED, 20);
        m_cc = m_cc + ((k == 0) ? 1 : k); m_st = PAUSED;
        n_chk++; if (cc32 !== m_cc || en_cnt32 !== ((k == 0) ? 1 : int'(k))) begin
          n_fail++; $display("FAIL rnd_step[%0d]: cycle=%0d en=%0d expected %0d/%0d", i, cc32, en_cnt32, m_cc, (k == 0) ? 1 : k);
        end
      end else if (r == 7) begin
        send(0, PAUSE, $urandom);
        @(negedge clk);
        n_chk++; if (er32 !== 1'b1 || st32 !== m_st || cc32 !== m_cc) begin
          n_fail++; $display("FAIL rnd_pause_err[%0d]: err=%0b state=%0d cycle=%0d expected 1/%0d/%0d", i, er32, st32, cc32, m_st, m_cc);
        end
      end else begin
        send(0, CLEAR, $urandom);
        m_cc = 0; m_st = IDLE;
        @(negedge clk);
        n_chk++; if (st32 !== IDLE || cc32 !== 32'd0) begin
          n_fail++; $display("FAIL rnd_clear[%0d]: state=%0d cycle=%0d expected %0d/0", i, st32, cc32, IDLE);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_to_done();
    test_pause_step();
    test_step_zero();
    test_run_zero();
    test_pause_at_limit();
    test_narrow();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
